// File: rtl/ddr_axi_write_master.sv
// rtl/ddr_axi_write_master.sv - FIFO-to-AXI4 fixed-length INCR write burst master over a circular DDR region.
// Optional stall watchdog with TimeoutErr output: define DDR_WR_TIMEOUT_EN.
module ddr_axi_write_master #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    BURST_LEN   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter logic [ADDR_WIDTH-1:0] REGION_SIZE = 'h0100_0000
) (
    input  logic                  Clk,
    input  logic                  RstN,
    input  logic                  En,
    input  logic                  FifoOverBurstThread,
    input  logic                  FifoEmpty,
    output logic                  FifoRdEn,
    input  logic [127:0]          FifoDataOut,
    input  logic                  FifoDataOutValid,
    output logic [7:0]            BurstThread,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [7:0]            M_AXI_AWLEN,
    output logic [2:0]            M_AXI_AWSIZE,
    output logic [1:0]            M_AXI_AWBURST,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [127:0]          M_AXI_WDATA,
    output logic [15:0]           M_AXI_WSTRB,
    output logic                  M_AXI_WLAST,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0] WrAddrCur,
    output logic [31:0]           BurstDoneCnt,
    output logic                  RespErr
`ifdef DDR_WR_TIMEOUT_EN
    ,
    output logic                  TimeoutErr
`endif
);

    localparam logic [ADDR_WIDTH:0] BURST_BYTES = (ADDR_WIDTH+1)'(BURST_LEN * 16);
    localparam logic [ADDR_WIDTH:0] REGION_END  = {1'b0, BASE_ADDR} + {1'b0, REGION_SIZE};
    localparam logic [7:0]          LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [8:0]          POP_LIMIT   = 9'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                  state, state_nxt;
    logic                    idle_ok;
    logic                    inflight;
    logic [1:0]              occ;
    logic [127:0]            buf0, buf1;
    logic [8:0]              pops_issued;
    logic [7:0]              beat_cnt;
    logic [ADDR_WIDTH-1:0]   addr_cur;
    logic [31:0]             done_cnt;
    logic                    resp_err;

    logic                    active, rd_en, push, wvalid, w_fire, wlast, b_fire;
    logic [ADDR_WIDTH:0]     addr_sum;
    logic [ADDR_WIDTH-1:0]   addr_nxt;

    always_comb begin
        active   = (state == ADDR) || (state == DATA);
        rd_en    = active && (pops_issued < POP_LIMIT) &&
                   (({1'b0, occ} + {2'b00, inflight}) < 3'd2) && !FifoEmpty;
        push     = FifoDataOutValid && active;
        wvalid   = (state == DATA) && (occ != 2'd0);
        w_fire   = wvalid && M_AXI_WREADY;
        wlast    = (state == DATA) && (beat_cnt == LAST_BEAT);
        b_fire   = (state == RESP) && M_AXI_BVALID;
        addr_sum = {1'b0, addr_cur} + BURST_BYTES;
        addr_nxt = (addr_sum >= REGION_END) ? BASE_ADDR : addr_sum[ADDR_WIDTH-1:0];
    end

    // idle_ok means the previous cycle was also IDLE, so the lagging threshold flag is current
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (idle_ok && En && FifoOverBurstThread && !FifoEmpty) state_nxt = ADDR;
            ADDR: if (M_AXI_AWREADY) state_nxt = DATA;
            DATA: if (w_fire && wlast) state_nxt = RESP;
            RESP: if (M_AXI_BVALID) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            state       <= IDLE;
            idle_ok     <= 1'b0;
            inflight    <= 1'b0;
            occ         <= 2'd0;
            pops_issued <= '0;
            beat_cnt    <= '0;
            addr_cur    <= BASE_ADDR;
            done_cnt    <= '0;
            resp_err    <= 1'b0;
        end else begin
            state    <= state_nxt;
            idle_ok  <= (state == IDLE);
            inflight <= rd_en;
            if (state == IDLE) begin
                pops_issued <= '0;
                beat_cnt    <= '0;
            end else begin
                if (rd_en)  pops_issued <= pops_issued + 9'd1;
                if (w_fire) beat_cnt    <= beat_cnt + 8'd1;
            end
            if (push && !w_fire)      occ <= occ + 2'd1;
            else if (!push && w_fire) occ <= occ - 2'd1;
            if (b_fire) begin
                done_cnt <= done_cnt + 32'd1;
                resp_err <= resp_err | (M_AXI_BRESP != 2'b00);
                addr_cur <= addr_nxt;
            end
        end
    end

    // Skid buffer datapath: buf0 is always the head presented on WDATA
    always_ff @(posedge Clk) begin
        case ({push, w_fire})
            2'b10: begin
                if (occ == 2'd0) buf0 <= FifoDataOut;
                else             buf1 <= FifoDataOut;
            end
            2'b01: buf0 <= buf1;
            2'b11: begin
                if (occ == 2'd1) begin
                    buf0 <= FifoDataOut;
                end else begin
                    buf0 <= buf1;
                    buf1 <= FifoDataOut;
                end
            end
            default: ;
        endcase
    end

`ifdef DDR_WR_TIMEOUT_EN
    logic [15:0] stall_cnt;
    logic        timeout_err;
    logic        any_hs;

    assign any_hs = (M_AXI_AWVALID && M_AXI_AWREADY) || w_fire || b_fire;

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE || any_hs)  stall_cnt <= '0;
            else if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (stall_cnt == 16'hFFFF) timeout_err <= 1'b1;
        end
    end

    assign TimeoutErr = timeout_err;
`endif

    assign FifoRdEn      = rd_en;
    assign BurstThread   = 8'(BURST_LEN);
    assign M_AXI_AWADDR  = addr_cur;
    assign M_AXI_AWLEN   = LAST_BEAT;
    assign M_AXI_AWSIZE  = 3'b100;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWVALID = (state == ADDR);
    assign M_AXI_WDATA   = buf0;
    assign M_AXI_WSTRB   = 16'hFFFF;
    assign M_AXI_WLAST   = wlast;
    assign M_AXI_WVALID  = wvalid;
    assign M_AXI_BREADY  = (state == RESP);
    assign WrAddrCur     = addr_cur;
    assign BurstDoneCnt  = done_cnt;
    assign RespErr       = resp_err;

endmodule
